regfile_param: RTL
==================

# regfile_param

Parametrised multi-register file with two combinational read ports and one synchronous write port. It adds optional write-to-read bypass, an optional hardwired-zero register 0, and a sequential bulk-clear engine with a busy/done handshake. It is the general-purpose register storage for the datapath, between instruction decode (source/destination indices) and the ALU/writeback stage.

## Interface
Parameters:
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 4, number of registers; power of two, ≥2
- ZERO_REG, 0, 1 = register 0 always reads zero and ignores writes
- BYPASS, 1, 1 = a same-cycle write to a register being read is forwarded to the read port
- AW (local), $clog2(DEPTH), index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- sr1  in  AW  read index, port 1
- sr2  in  AW  read index, port 2
- rd_data1  out  WIDTH  read data, port 1 (combinational)
- rd_data2  out  WIDTH  read data, port 2 (combinational)
- write  in  1  write enable
- dr  in  AW  write index
- wr_data  in  WIDTH  write data
- clr_req  in  1  start bulk clear (level sampled on clk)
- clr_busy  out  1  clear engine active; writes are dropped
- clr_done  out  1  one-cycle pulse when clear completes

## Operation
- Reset (rst_n low, asynchronous): all registers 0, FSM IDLE, clr_busy=0, clr_done=0; rd_data outputs therefore read 0.
- Effective write: we_eff = write & (state==IDLE) & ~clr_req & ~(ZERO_REG & dr==0). When we_eff is high, reg[dr] <= wr_data on the rising edge.
- Read: rd_dataN = reg[srN]. Overrides, highest priority first:
  - ZERO_REG & srN==0 → 0.
  - BYPASS & we_eff & dr==srN → wr_data.
- Both ports may address the same register; they return identical data.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE → CLEAR when clr_req=1; ptr <= 0.
  - CLEAR: reg[ptr] <= 0 each cycle; ptr increments. Leave for DONE after ptr==DEPTH-1 is cleared.
  - DONE: clr_done=1 for one cycle, then → IDLE.
  - clr_busy = (state==CLEAR).
- clr_req in CLEAR or DONE is ignored; it does not restart or extend the clear.
- Writes are dropped when they occur in the clr_req cycle, during CLEAR, or during DONE. No error flag is raised.
- Reads are permitted throughout the clear. Already-cleared registers read 0; the rest return old contents. Bypass never fires, because we_eff=0.
- Reset asserted mid-clear: immediate return to IDLE with all registers 0.

## Timing
- Read latency 0 cycles (combinational from srN and register state).
- Write visible on the read ports the cycle after the edge; with BYPASS=1, also visible in the same cycle.
- Clear: clr_req sampled at edge E0. clr_busy is high for cycles E0+1 through E0+DEPTH (DEPTH cycles). clr_done is high for cycle E0+DEPTH+1. The first new write is accepted at edge E0+DEPTH+2.
- Wrap: ptr is AW bits wide; ptr==DEPTH-1 terminates the clear, so ptr never wraps during the clear.

## Structure
- Shared package regfile_pkg holds the FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and an index-width function used by all register-file variants.
- One sub-module, regfile_clr_fsm:
  - Owns state, ptr, clr_busy and clr_done.
  - Outputs clr_we and clr_idx to the storage array.
- Storage array, write decode, bypass and read muxes stay in regfile_param.

## Test plan
- Reset then basic write/read (WIDTH=32, DEPTH=4): all reads 0 after reset. Write 0xDEADBEEF to r2, then 0x12345678 to r3. Next cycle, sr1=2/sr2=3 → rd_data1=0xDEADBEEF, rd_data2=0x12345678.
- Bypass (BYPASS=1): write=1, dr=1, wr_data=0xA5A5A5A5, sr1=1 → rd_data1=0xA5A5A5A5 in the same cycle. With BYPASS=0, the old value is returned until the next cycle.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 → sr1=0 reads 0 both same cycle and next cycle. r1 is unaffected.
- Bulk clear (DEPTH=8): preload r0..r7 with 0x10..0x17 and pulse clr_req.
  - clr_busy is high for exactly 8 cycles, then clr_done pulses once; all registers then read 0.
  - A read of r7 during busy cycle 4 returns 0x17.
  - A write of 0x99 to r5 during busy is dropped; r5=0 after done.
- Clear request while busy: clr_req held high throughout → clr_busy stays 8 cycles and clr_done pulses once. clr_req re-asserted after done → a new 8-cycle clear starts.
- Async reset mid-clear: rst_n low at busy cycle 3, asserted between clock edges → clr_busy=0 immediately (no clock edge needed), all reads 0. After release, a write of 0x5 to r2 is accepted on the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state encoding and index-width helper for register files
package regfile_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} clr_state_e;
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential bulk-clear engine walking every register index once
module regfile_clr_fsm import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          idle,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);
  clr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q, done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clr_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign idle     = state_q == IDLE;
  assign clr_we   = busy_q;
  assign clr_idx  = ptr_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with bypass, optional zero register and bulk clear
module regfile_param import regfile_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             write,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             idle, clr_we, we_eff;
  logic [AW-1:0]    clr_idx;
  regfile_clr_fsm #(.DEPTH(DEPTH)) u_clr (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done), .idle(idle), .clr_we(clr_we), .clr_idx(clr_idx)
  );
  // A write in the request cycle is dropped so the clear starts from a stable snapshot
  assign we_eff = write && idle && !clr_req && !(ZERO_REG != 0 && dr == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    else if (clr_we) regs_q[clr_idx] <= '0;
    else if (we_eff) regs_q[dr] <= wr_data;
  end
  assign rd_data1 = (ZERO_REG != 0 && sr1 == '0) ? '0 :
                    (BYPASS != 0 && we_eff && dr == sr1) ? wr_data : regs_q[sr1];
  assign rd_data2 = (ZERO_REG != 0 && sr2 == '0) ? '0 :
                    (BYPASS != 0 && we_eff && dr == sr2) ? wr_data : regs_q[sr2];
endmodule
